// File: rtl/execute_writeback_unit.sv
// Execute/memory/writeback stage: evaluates the ALU op, runs data-memory accesses
// over a req/ack handshake with timeout, and drives register-file writeback, branch and display.
module execute_writeback_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  aluControl_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        mem_en_i,
  input  logic        mem_wr_i,
  input  logic [10:0] mem_addr_i,
  input  logic        branch_en_i,
  input  logic [19:0] pc_imm_i,
  input  logic        displayEn_i,
  input  logic [4:0]  wbAddr_i,
  input  logic        wbEnable_i,
  output logic [31:0] write_data_o,
  output logic [4:0]  wbAddr_o,
  output logic        wbEnable_o,
  output logic        stall_o,
  output logic        branch_o,
  output logic [19:0] branch_imm_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [10:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [31:0] display_o,
  output logic        display_valid_o,
  output logic        err_o
);

  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [9:0] TO_LAST = 10'(ACK_TIMEOUT - 1);

  function automatic logic [31:0] alu_result(input logic [3:0] ctl,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    case (ctl)
      4'b0000:          r = a + b;
      4'b1000:          r = a - b;
      4'b0001:          r = a << sh;
      4'b0101, 4'b1011: r = $unsigned(a) >> sh;
      4'b1001, 4'b1100: r = a >>> sh;
      4'b0010:          r = {31'd0, a < b};
      4'b0011:          r = {31'd0, $unsigned(a) < $unsigned(b)};
      4'b0100:          r = a ^ b;
      4'b0110:          r = a | b;
      4'b0111:          r = a & b;
      4'b1101:          r = a << 12;
      default:          r = '0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        wb_en_q, wb_en_d;
  logic        branch_q, branch_d;
  logic [19:0] bimm_q, bimm_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [10:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [31:0] disp_q, disp_d;
  logic        disp_vld_q, disp_vld_d;
  logic        err_q, err_d;
  logic [4:0]  cap_addr_q, cap_addr_d;
  logic        cap_en_q, cap_en_d;
  logic signed [31:0] res;

  assign res = alu_result(aluControl_i, op1_i, op2_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    wb_addr_d  = wb_addr_q;
    wb_en_d    = 1'b0;
    branch_d   = 1'b0;
    bimm_d     = bimm_q;
    req_d      = req_q;
    we_d       = we_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    disp_d     = disp_q;
    disp_vld_d = 1'b0;
    err_d      = err_q;
    cap_addr_d = cap_addr_q;
    cap_en_d   = cap_en_q;
    stall_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_en_i) begin
          branch_d = 1'b1;
          bimm_d   = pc_imm_i;
        end
        if (displayEn_i) begin
          disp_d     = op1_i;
          disp_vld_d = 1'b1;
        end
        if (mem_en_i) begin
          stall_o    = 1'b1;
          req_d      = 1'b1;
          we_d       = mem_wr_i;
          maddr_d    = mem_addr_i;
          mwdata_d   = op1_i;
          cap_addr_d = wbAddr_i;
          cap_en_d   = wbEnable_i;
          cnt_d      = '0;
          state_d    = MEM_WAIT;
        end else begin
          wdata_d   = res;
          wb_addr_d = wbAddr_i;
          wb_en_d   = wbEnable_i & (wbAddr_i != 5'd0);
        end
      end
      MEM_WAIT: begin
        stall_o = !dmem_ack_i;
        // A same-cycle ack wins over the timeout, so it is tested first.
        if (dmem_ack_i || cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!dmem_ack_i) begin
            err_d = 1'b1;
            cnt_d = cnt_q + 10'd1;
          end
          if (!we_q) begin
            wdata_d   = dmem_ack_i ? dmem_rdata_i : 32'd0;
            wb_addr_d = cap_addr_q;
            wb_en_d   = cap_en_q & (cap_addr_q != 5'd0);
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      wb_addr_q  <= '0;
      wb_en_q    <= 1'b0;
      branch_q   <= 1'b0;
      bimm_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      err_q      <= 1'b0;
      cap_addr_q <= '0;
      cap_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      wb_addr_q  <= wb_addr_d;
      wb_en_q    <= wb_en_d;
      branch_q   <= branch_d;
      bimm_q     <= bimm_d;
      req_q      <= req_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      disp_q     <= disp_d;
      disp_vld_q <= disp_vld_d;
      err_q      <= err_d;
      cap_addr_q <= cap_addr_d;
      cap_en_q   <= cap_en_d;
    end
  end

  assign write_data_o    = wdata_q;
  assign wbAddr_o        = wb_addr_q;
  assign wbEnable_o      = wb_en_q;
  assign branch_o        = branch_q;
  assign branch_imm_o    = bimm_q;
  assign dmem_req_o      = req_q;
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = maddr_q;
  assign dmem_wdata_o    = mwdata_q;
  assign display_o       = disp_q;
  assign display_valid_o = disp_vld_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_execute_writeback_unit.sv
// Testbench for execute_writeback_unit: directed and randomized scenarios checked
// against an arithmetic reference model of the ALU and memory handshake.
module tb_execute_writeback_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  aluControl;
  logic [31:0] op1, op2;
  logic        mem_en, mem_wr;
  logic [10:0] mem_addr;
  logic        branch_en;
  logic [19:0] pc_imm;
  logic        displayEn;
  logic [4:0]  wbAddr;
  logic        wbEnable;
  logic [31:0] write_data;
  logic [4:0]  wbAddr_out;
  logic        wbEnable_out, stall, branch, dmem_req, dmem_we;
  logic [19:0] branch_imm;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata, display;
  logic        dmem_ack, display_valid, err;

  int checks = 0;
  int errors = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  execute_writeback_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .aluControl_i(aluControl), .op1_i(op1), .op2_i(op2),
    .mem_en_i(mem_en), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr), .branch_en_i(branch_en),
    .pc_imm_i(pc_imm), .displayEn_i(displayEn), .wbAddr_i(wbAddr), .wbEnable_i(wbEnable),
    .write_data_o(write_data), .wbAddr_o(wbAddr_out), .wbEnable_o(wbEnable_out),
    .stall_o(stall), .branch_o(branch), .branch_imm_o(branch_imm), .dmem_req_o(dmem_req),
    .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack), .display_o(display),
    .display_valid_o(display_valid), .err_o(err)
  );

  // Reference ALU in 64-bit integer arithmetic: shifts as multiply/divide by powers of two.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa, sb, p, r;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    p  = longint'(1) << b[4:0];
    case (c)
      4'd0:         r = ua + ub;
      4'd8:         r = ua - ub;
      4'd1:         r = ua * p;
      4'd5, 4'd11:  r = ua / p;
      4'd9, 4'd12:  r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd2:         r = (sa < sb) ? 1 : 0;
      4'd3:         r = (ua < ub) ? 1 : 0;
      4'd4:         r = ua ^ ub;
      4'd6:         r = ua | ub;
      4'd7:         r = ua & ub;
      4'd13:        r = ua * 4096;
      default:      r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic set_idle();
    aluControl = '0; op1 = '0; op2 = '0; mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0;
    branch_en = 1'b0; pc_imm = '0; displayEn = 1'b0; wbAddr = '0; wbEnable = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    aluControl = 4'd0; op1 = $urandom; op2 = $urandom; wbAddr = 5'd9; wbEnable = 1'b1;
    branch_en = 1'b1; pc_imm = 20'hABCDE; displayEn = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({write_data, wbAddr_out, wbEnable_out, branch, branch_imm, dmem_req, dmem_we,
         dmem_addr, dmem_wdata, display, display_valid, err} !== '0) begin
      errors++; $display("FAIL reset_outputs got wd=%h wa=%h we=%b br=%b req=%b disp=%h err=%b exp all 0",
                         write_data, wbAddr_out, wbEnable_out, branch, dmem_req, display, err);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    reset = 1'b0;
    set_idle();
    aluControl = 4'b0000; op1 = 32'd7; op2 = -32'sd3; wbAddr = 5'd5; wbEnable = 1'b1;
    @(negedge clk);
    checks++;
    if ({write_data, wbAddr_out, wbEnable_out} !== {32'd4, 5'd5, 1'b1}) begin
      errors++; $display("FAIL first_add got %h/%0d/%b exp 4/5/1", write_data, wbAddr_out, wbEnable_out);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [3:0]  tc[9]  = '{4'b1000, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1101, 4'b1111, 4'b1010, 4'b1100};
    logic [31:0] ta[9]  = '{32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'h12345, 32'h1234, 32'h55, 32'h80000000};
    logic [31:0] tb_[9] = '{32'd9, 32'd4, 32'd4, 32'd1, 32'd1, 32'd0, 32'd7, 32'd3, 32'd4};
    logic [31:0] te[9]  = '{32'hFFFFFFFC, 32'hF8000000, 32'h08000000, 32'd0, 32'd1,
                           32'h12345000, 32'd0, 32'd0, 32'hF8000000};
    logic [31:0] exp_d;
    logic        exp_e;
    for (int i = 0; i < 49; i++) begin
      set_idle();
      if (i < 9) begin
        aluControl = tc[i]; op1 = ta[i]; op2 = tb_[i]; wbAddr = 5'd10; wbEnable = 1'b1;
        exp_d = te[i];
      end else begin
        aluControl = 4'($urandom); op1 = $urandom; op2 = $urandom;
        wbAddr = 5'($urandom); wbEnable = 1'($urandom);
        exp_d = ref_alu(aluControl, op1, op2);
      end
      exp_e = wbEnable && (wbAddr != 5'd0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall[%0d] got %b exp 0", i, stall); end
      @(negedge clk);
      checks++;
      if ({write_data, wbAddr_out, wbEnable_out} !== {exp_d, wbAddr, exp_e}) begin
        errors++; $display("FAIL alu[%0d] ctl=%b got %h/%0d/%b exp %h/%0d/%b", i, aluControl,
                           write_data, wbAddr_out, wbEnable_out, exp_d, wbAddr, exp_e);
      end
    end
    set_idle();
    @(negedge clk);
  endtask

  // One memory access; waits >= TO means the ack never comes and the access times out.
  task automatic do_mem(input logic wr, input logic [10:0] addr, input logic [31:0] d,
                        input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    bit tmo;
    int ncyc;
    logic [31:0] exp_d;
    tmo  = (waits >= TO);
    ncyc = tmo ? TO : waits + 1;
    set_idle();
    aluControl = 4'($urandom); op1 = d; op2 = $urandom; mem_en = 1'b1; mem_wr = wr;
    mem_addr = addr; wbAddr = rd; wbEnable = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mem_stall_issue got %b exp 1", stall); end
    @(negedge clk);
    for (int i = 0; i < ncyc; i++) begin
      op1 = $urandom; op2 = $urandom; mem_addr = 11'($urandom); mem_wr = 1'($urandom);
      wbAddr = 5'($urandom); branch_en = 1'($urandom); displayEn = 1'($urandom);
      dmem_ack = !tmo && (i == ncyc - 1);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wbEnable_out, stall, branch, display_valid}
          !== {1'b1, wr, addr, d, 1'b0, !dmem_ack, 1'b0, 1'b0}) begin
        errors++; $display("FAIL mem_wait[%0d] got req=%b we=%b a=%h wd=%h wbe=%b st=%b br=%b dv=%b exp req=1 we=%b a=%h wd=%h wbe=0 st=%b br=0 dv=0",
                           i, dmem_req, dmem_we, dmem_addr, dmem_wdata, wbEnable_out, stall,
                           branch, display_valid, wr, addr, d, !dmem_ack);
      end
      @(negedge clk);
    end
    set_idle();
    #1;
    err_exp = err_exp | tmo;
    exp_d = tmo ? 32'd0 : rdata;
    checks++;
    if ({dmem_req, stall, err, wbEnable_out} !== {1'b0, 1'b0, err_exp, !wr && (rd != 5'd0)}) begin
      errors++; $display("FAIL mem_done got req=%b st=%b err=%b wbe=%b exp req=0 st=0 err=%b wbe=%b",
                         dmem_req, stall, err, wbEnable_out, err_exp, !wr && (rd != 5'd0));
    end
    if (!wr) begin
      checks++;
      if ({write_data, wbAddr_out} !== {exp_d, rd}) begin
        errors++; $display("FAIL mem_load_wb got %h/%0d exp %h/%0d", write_data, wbAddr_out, exp_d, rd);
      end
    end
    @(negedge clk);
    checks++;
    if ({wbEnable_out, err} !== {1'b0, err_exp}) begin
      errors++; $display("FAIL mem_after got wbe=%b err=%b exp 0/%b", wbEnable_out, err, err_exp);
    end
  endtask

  task automatic test_memory();
    do_mem(1'b0, 11'h010, 32'h0, 5'd3, 3, 32'hDEADBEEF);
    do_mem(1'b1, 11'h7FF, 32'hA5A5A5A5, 5'd4, 0, 32'h0);
    for (int i = 0; i < 8; i++)
      do_mem(1'($urandom), 11'($urandom), $urandom, 5'($urandom), $urandom_range(0, TO - 1), $urandom);
  endtask

  task automatic test_timeout();
    do_mem(1'b0, 11'h123, 32'h0, 5'd6, TO, 32'h0);
    do_mem(1'b0, 11'h055, 32'h0, 5'd7, 1, 32'h13572468);
    do_mem(1'b1, 11'h0AA, 32'h11112222, 5'd8, TO + 3, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    mem_en = 1'b1; mem_addr = 11'h033; wbAddr = 5'd9; wbEnable = 1'b1;
    @(negedge clk);
    set_idle();
    @(negedge clk);
    checks++;
    if ({dmem_req, err} !== {1'b1, err_exp}) begin
      errors++; $display("FAIL mid_wait_pre got req=%b err=%b exp 1/%b", dmem_req, err, err_exp);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
    checks++;
    if ({dmem_req, err, wbEnable_out, write_data, stall} !== {1'b0, 1'b0, 1'b0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL mid_wait_reset got req=%b err=%b wbe=%b wd=%h st=%b exp all 0",
                         dmem_req, err, wbEnable_out, write_data, stall);
    end
    aluControl = 4'b0000; op1 = 32'd1; op2 = 32'd2; wbAddr = 5'd7; wbEnable = 1'b1;
    @(negedge clk);
    checks++;
    if ({write_data, wbAddr_out, wbEnable_out} !== {32'd3, 5'd7, 1'b1}) begin
      errors++; $display("FAIL post_reset_add got %h/%0d/%b exp 3/7/1", write_data, wbAddr_out, wbEnable_out);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_sequence();
    set_idle();
    aluControl = 4'b0000; op1 = 32'h100; op2 = 32'd4; pc_imm = 20'h00800; branch_en = 1'b1;
    wbAddr = 5'd1; wbEnable = 1'b1;
    @(negedge clk);
    checks++;
    if ({branch, branch_imm, write_data, wbEnable_out} !== {1'b1, 20'h00800, 32'h104, 1'b1}) begin
      errors++; $display("FAIL jal got br=%b imm=%h wd=%h wbe=%b exp 1/00800/104/1",
                         branch, branch_imm, write_data, wbEnable_out);
    end
    set_idle();
    op1 = 32'd42; displayEn = 1'b1; dmem_ack = 1'b1; dmem_rdata = $urandom;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL idle_ack_stall got %b exp 0", stall); end
    @(negedge clk);
    checks++;
    if ({branch, branch_imm, display, display_valid, dmem_req} !== {1'b0, 20'h00800, 32'd42, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ecall got br=%b imm=%h disp=%0d dv=%b req=%b exp 0/00800/42/1/0",
                         branch, branch_imm, display, display_valid, dmem_req);
    end
    set_idle();
    aluControl = 4'b0000; op1 = 32'd5; op2 = 32'd6; wbAddr = 5'd0; wbEnable = 1'b1;
    @(negedge clk);
    checks++;
    if ({wbEnable_out, display, display_valid, write_data} !== {1'b0, 32'd42, 1'b0, 32'd11}) begin
      errors++; $display("FAIL add_x0 got wbe=%b disp=%0d dv=%b wd=%h exp 0/42/0/b",
                         wbEnable_out, display, display_valid, write_data);
    end
    set_idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_timeout();
    test_reset_mid_wait();
    test_sequence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
